prio_int_controller: RTL and testbench
======================================

PRIO_INT_CONTROLLER -- requirements
Module: prio_int_controller

Interface
- REQ-001: Parameter NCH, default 4: number of interrupt channels, 2..15.
- REQ-002: Parameter IDW, default 3: C_IRQ width; SHALL equal clog2(NCH+1).
- REQ-003: Parameter EDGE_SEL, NCH bits, default all 0: per-channel mode; bit i = 1 means channel i is rising-edge, 0 means level.
- REQ-004: CLK  in  1  single clock; all state updates on rising edge.
- REQ-005: RESET  in  1  asynchronous, active-low reset; low forces the reset state immediately.
- REQ-006: IRQ  in  [0:NCH-1]  device interrupt requests; index 0 is highest priority.
- REQ-007: IMASK  in  [0:NCH-1]  per-channel mask; 1 blocks the channel from selection.
- REQ-008: C_IACK  in  1  CPU acknowledge, sampled on CLK.
- REQ-009: C_IEND  in  1  CPU end-of-service, sampled on CLK.
- REQ-010: C_IRQ  out  IDW  registered request code to CPU: 0 = none, k = channel k-1.
- REQ-011: IACK  out  [0:NCH-1]  one-hot, one-cycle acknowledge pulse to the selected device.
- REQ-012: IEND  out  [0:NCH-1]  one-hot, one-cycle end-of-service pulse to the selected device.
- REQ-013: PEND  out  [0:NCH-1]  current pending vector, before masking.
- REQ-014: BUSY  out  1  high in every state except IDLE.

Function
- REQ-015: Edge channel pending bit SHALL set on the cycle after IRQ[i] is sampled 0 then 1, and SHALL stay set until acknowledged.
- REQ-016: Level channel pending bit SHALL equal the registered IRQ[i], one cycle after the input.
- REQ-017: Eligible vector SHALL be PEND & ~IMASK; the lowest eligible index wins.
- REQ-018: FSM states SHALL be IDLE, REQ, ACK, SERVICE and END.
- REQ-019: IDLE -> REQ when any channel is eligible; the winner is latched as SEL and C_IRQ = SEL+1 from the same edge.
- REQ-020: In REQ, C_IRQ and SEL SHALL stay constant; there is no preemption, and a later higher-priority request, a mask change or a level IRQ withdrawal does not alter them.
- REQ-021: REQ -> ACK when C_IACK is sampled 1; in ACK, IACK[SEL] = 1 for exactly one cycle and C_IRQ = 0.
- REQ-022: On the ACK transition, the pending bit of an edge SEL channel SHALL clear; an edge on the same channel in that same cycle SHALL re-set it.
- REQ-023: ACK -> SERVICE unconditionally; SERVICE holds, with C_IRQ = 0, until C_IEND is sampled 1.
- REQ-024: SERVICE -> END on C_IEND; in END, IEND[SEL] = 1 for one cycle; END -> IDLE unconditionally.
- REQ-025: C_IEND in IDLE, REQ or ACK and C_IACK in any state other than REQ SHALL be ignored.
- REQ-026: C_IACK and C_IEND both 1 in REQ: only C_IACK acts.
- REQ-027: Edges arriving during REQ through END SHALL be latched; they are served after return to IDLE, at least one IDLE cycle later.
- REQ-028: IACK and IEND SHALL never be nonzero simultaneously, and each SHALL have at most one bit set.

Reset
- REQ-029: While RESET = 0, the block SHALL hold state = IDLE, C_IRQ = 0, IACK = 0, IEND = 0, PEND = 0, BUSY = 0, SEL = 0, and the edge-detect history = 0.
- REQ-030: Reset asserted mid-handshake SHALL abort the transaction with no IACK or IEND pulse; pending edges are lost.
- REQ-031: After release, an IRQ already high on an edge channel SHALL count as a new edge, because the history resets to 0.

Verification (NCH=2, EDGE_SEL=00, IMASK=00 unless stated)
- REQ-032: Handshake on IRQ=10 -> C_IRQ=1 within 2 cycles; C_IACK pulse -> IACK=10 for 1 cycle; C_IEND pulse -> IEND=10 for 1 cycle; then BUSY=0.
- REQ-033: Priority with IRQ=11 -> C_IRQ=1; after full handshake with IRQ held at 01 -> C_IRQ=2 and IACK=01.
- REQ-034: No preemption: IRQ=01, C_IRQ=2, then IRQ=11 before C_IACK -> C_IRQ stays 2 and the C_IACK pulse gives IACK=01.
- REQ-035: EDGE_SEL=01, single-cycle IRQ[1] pulse while channel 0 is in SERVICE -> PEND=01 held; after IEND=10, C_IRQ=2 follows.
- REQ-036: IMASK=10 with IRQ=11 -> C_IRQ=2; with IMASK=11 -> C_IRQ=0 and PEND=11.
- REQ-037: RESET low during SERVICE -> all outputs 0 immediately; RESET high with IRQ=00 -> IDLE and no IEND pulse.

Source files
------------

// File: rtl/prio_int_controller.sv
// Purpose : fixed-priority interrupt controller, NCH channels (index 0 highest), CPU request/ack/end handshake.
// Latency : level IRQ -> PEND 1 cycle, PEND -> C_IRQ 1 cycle; IACK/IEND are single-cycle pulses.
// Backpressure: the CPU paces the handshake through C_IACK/C_IEND; new requests wait (latched if edge) until IDLE.
//
// Ports:
//   CLK, RESET    clock (rising edge), asynchronous active-low reset
//   IRQ, IMASK    device requests and per-channel mask ([0] = highest priority)
//   C_IACK/C_IEND CPU acknowledge / end-of-service strobes
//   C_IRQ         request code to CPU: 0 = none, k = channel k-1
//   IACK/IEND     one-hot single-cycle pulses to the selected device
//   PEND, BUSY    unmasked pending vector, controller not idle
module prio_int_controller #(
    parameter int             NCH      = 4,
    parameter int             IDW      = 3,
    parameter logic [0:NCH-1] EDGE_SEL = '0
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic [0:NCH-1] IRQ,
    input  logic [0:NCH-1] IMASK,
    input  logic           C_IACK,
    input  logic           C_IEND,
    output logic [IDW-1:0] C_IRQ,
    output logic [0:NCH-1] IACK,
    output logic [0:NCH-1] IEND,
    output logic [0:NCH-1] PEND,
    output logic           BUSY
);

    localparam logic [IDW-1:0] ID_ONE = IDW'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_ACK     = 3'd2,
        S_SERVICE = 3'd3,
        S_END     = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [0:NCH-1] r_irq_q;
    logic [0:NCH-1] r_pend_edge;
    logic [IDW-1:0] r_sel;
    logic [IDW-1:0] r_c_irq;

    logic [0:NCH-1] w_rise;
    logic [0:NCH-1] w_pend;
    logic [0:NCH-1] w_elig;
    logic [0:NCH-1] w_clr;
    logic [IDW-1:0] w_win;
    logic           w_any;
    logic           w_take;
    logic           w_ack;

    // Pending / eligibility / priority encode
    always_comb begin
        w_rise = IRQ & ~r_irq_q;
        // Edge channels read the sticky latch; level channels read the registered input.
        w_pend = (EDGE_SEL & r_pend_edge) | (~EDGE_SEL & r_irq_q);
        w_elig = w_pend & ~IMASK;
        w_any  = |w_elig;
        w_win  = '0;
        // Walk from lowest priority upward so the lowest eligible index is left standing.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win = IDW'(i);
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_ack       = 1'b0;
        w_clr       = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_REQ;
                    w_take      = 1'b1;
                end
            end
            S_REQ: begin
                // C_IEND is deliberately not looked at here, so IACK wins when both are high.
                if (C_IACK) begin
                    w_state_nxt = S_ACK;
                    w_ack       = 1'b1;
                    for (int i = 0; i < NCH; i++) begin
                        if (r_sel == IDW'(i)) begin
                            w_clr[i] = 1'b1;
                        end
                    end
                end
            end
            S_ACK:     w_state_nxt = S_SERVICE;
            S_SERVICE: begin
                if (C_IEND) begin
                    w_state_nxt = S_END;
                end
            end
            S_END:     w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_irq_q     <= '0;
            r_pend_edge <= '0;
            r_sel       <= '0;
            r_c_irq     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_irq_q <= IRQ;
            // Clear before set: an edge coinciding with the acknowledge re-arms the channel.
            r_pend_edge <= ((r_pend_edge & ~w_clr) | w_rise) & EDGE_SEL;
            if (w_take) begin
                r_sel   <= w_win;
                r_c_irq <= w_win + ID_ONE;
            end else if (w_ack) begin
                r_c_irq <= '0;
            end
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        IACK = '0;
        IEND = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_sel == IDW'(i)) begin
                IACK[i] = (r_state == S_ACK);
                IEND[i] = (r_state == S_END);
            end
        end
    end

    assign C_IRQ = r_c_irq;
    assign PEND  = w_pend;
    assign BUSY  = (r_state != S_IDLE);

endmodule

// File: tb/tb_prio_int_controller.sv
// Purpose : directed self-checking bench for prio_int_controller, NCH=2 (all-level and ch1-edge instances).
// Latency : inputs driven and outputs sampled 1 time unit after each rising CLK edge.
// Backpressure: none; the bench plays the CPU and devices directly.
module tb_prio_int_controller;

    logic       CLK = 1'b0;
    logic       rst_n;

    logic [0:1] a_irq, a_imask, a_iack, a_iend, a_pend;
    logic       a_ciack, a_ciend, a_busy;
    logic [1:0] a_cirq;

    logic [0:1] b_irq, b_imask, b_iack, b_iend, b_pend;
    logic       b_ciack, b_ciend, b_busy;
    logic [1:0] b_cirq;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    prio_int_controller #(.NCH(2), .IDW(2), .EDGE_SEL(2'b00)) u_lvl (
        .CLK(CLK), .RESET(rst_n), .IRQ(a_irq), .IMASK(a_imask),
        .C_IACK(a_ciack), .C_IEND(a_ciend), .C_IRQ(a_cirq),
        .IACK(a_iack), .IEND(a_iend), .PEND(a_pend), .BUSY(a_busy)
    );

    prio_int_controller #(.NCH(2), .IDW(2), .EDGE_SEL(2'b01)) u_edge (
        .CLK(CLK), .RESET(rst_n), .IRQ(b_irq), .IMASK(b_imask),
        .C_IACK(b_ciack), .C_IEND(b_ciend), .C_IRQ(b_cirq),
        .IACK(b_iack), .IEND(b_iend), .PEND(b_pend), .BUSY(b_busy)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        a_irq   = 2'b10; a_imask = 2'b00; a_ciack = 1'b0; a_ciend = 1'b0;
        b_irq   = 2'b00; b_imask = 2'b00; b_ciack = 1'b0; b_ciend = 1'b0;

        // Reset state, with a request held high during reset
        step();
        chk("rst_cirq", 8'(a_cirq), 8'd0);
        chk("rst_iack", 8'(a_iack), 8'd0);
        chk("rst_iend", 8'(a_iend), 8'd0);
        chk("rst_pend", 8'(a_pend), 8'd0);
        chk("rst_busy", 8'(a_busy), 8'd0);
        chk("rst_busy_b", 8'(b_busy), 8'd0);
        a_irq = 2'b00;
        rst_n = 1'b1;
        step();
        chk("idle_pend", 8'(a_pend), 8'd0);
        chk("idle_busy", 8'(a_busy), 8'd0);

        // Basic handshake on channel 0
        a_irq = 2'b10;
        step();
        chk("hs_pend", 8'(a_pend), 8'(2'b10));
        chk("hs_cirq_early", 8'(a_cirq), 8'd0);
        step();
        chk("hs_cirq", 8'(a_cirq), 8'd1);
        chk("hs_busy", 8'(a_busy), 8'd1);
        a_ciend = 1'b1;                       // ignored in REQ
        step();
        chk("hs_iend_in_req", 8'(a_iend), 8'd0);
        chk("hs_cirq_hold", 8'(a_cirq), 8'd1);
        a_ciend = 1'b0;
        a_ciack = 1'b1;
        step();
        chk("hs_iack", 8'(a_iack), 8'(2'b10));
        chk("hs_cirq_ack", 8'(a_cirq), 8'd0);
        a_ciack = 1'b0;
        step();
        chk("hs_iack_1cyc", 8'(a_iack), 8'd0);
        chk("hs_busy_svc", 8'(a_busy), 8'd1);
        a_irq   = 2'b00;
        a_ciend = 1'b1;
        step();
        chk("hs_iend", 8'(a_iend), 8'(2'b10));
        chk("hs_iack_off", 8'(a_iack), 8'd0);
        a_ciend = 1'b0;
        step();
        chk("hs_iend_1cyc", 8'(a_iend), 8'd0);
        chk("hs_busy_done", 8'(a_busy), 8'd0);

        // Priority: both request, channel 0 first, then channel 1
        a_irq = 2'b11;
        step();
        chk("pr_pend", 8'(a_pend), 8'(2'b11));
        step();
        chk("pr_cirq0", 8'(a_cirq), 8'd1);
        a_irq   = 2'b01;
        a_ciack = 1'b1;
        step();
        chk("pr_iack0", 8'(a_iack), 8'(2'b10));
        a_ciack = 1'b0;
        step();
        a_ciend = 1'b1;
        step();
        chk("pr_iend0", 8'(a_iend), 8'(2'b10));
        a_ciend = 1'b0;
        step();
        chk("pr_idle_gap", 8'(a_busy), 8'd0);
        step();
        chk("pr_cirq1", 8'(a_cirq), 8'd2);

        // No preemption by a later higher-priority request
        a_irq = 2'b11;
        step();
        step();
        chk("np_pend", 8'(a_pend), 8'(2'b11));
        chk("np_cirq", 8'(a_cirq), 8'd2);
        a_ciack = 1'b1;
        step();
        chk("np_iack", 8'(a_iack), 8'(2'b01));
        a_ciack = 1'b0;
        step();
        a_ciack = 1'b1;                       // ignored in SERVICE
        step();
        chk("np_iack_in_svc", 8'(a_iack), 8'd0);
        chk("np_busy_svc", 8'(a_busy), 8'd1);
        chk("np_cirq_svc", 8'(a_cirq), 8'd0);
        a_ciack = 1'b0;
        a_irq   = 2'b00;
        a_ciend = 1'b1;
        step();
        chk("np_iend", 8'(a_iend), 8'(2'b01));
        a_ciend = 1'b0;
        step();
        chk("np_busy_done", 8'(a_busy), 8'd0);

        // Masking, and IACK/IEND together in REQ
        a_imask = 2'b10;
        a_irq   = 2'b11;
        step();
        step();
        chk("mk_cirq", 8'(a_cirq), 8'd2);
        a_ciack = 1'b1;
        a_ciend = 1'b1;
        step();
        chk("mk_iack_both", 8'(a_iack), 8'(2'b01));
        chk("mk_iend_both", 8'(a_iend), 8'd0);
        a_ciack = 1'b0;
        a_ciend = 1'b0;
        a_imask = 2'b11;
        step();
        chk("mk_busy_svc", 8'(a_busy), 8'd1);
        chk("mk_iend_svc", 8'(a_iend), 8'd0);
        a_ciend = 1'b1;
        step();
        chk("mk_iend", 8'(a_iend), 8'(2'b01));
        a_ciend = 1'b0;
        step();
        step();
        chk("mk_all_cirq", 8'(a_cirq), 8'd0);
        chk("mk_all_pend", 8'(a_pend), 8'(2'b11));
        chk("mk_all_busy", 8'(a_busy), 8'd0);

        // Reset during SERVICE
        a_imask = 2'b00;
        a_irq   = 2'b10;
        step();
        chk("rs_cirq", 8'(a_cirq), 8'd1);
        a_ciack = 1'b1;
        step();
        a_ciack = 1'b0;
        step();
        chk("rs_busy_svc", 8'(a_busy), 8'd1);
        rst_n = 1'b0;
        #1;
        chk("rs_busy", 8'(a_busy), 8'd0);
        chk("rs_cirq0", 8'(a_cirq), 8'd0);
        chk("rs_iack", 8'(a_iack), 8'd0);
        chk("rs_iend", 8'(a_iend), 8'd0);
        chk("rs_pend", 8'(a_pend), 8'd0);
        a_irq = 2'b00;
        step();
        rst_n   = 1'b1;
        a_ciend = 1'b1;                       // ignored in IDLE
        step();
        chk("rs_no_iend", 8'(a_iend), 8'd0);
        chk("rs_idle", 8'(a_busy), 8'd0);
        a_ciend = 1'b0;
        step();
        chk("rs_no_iend2", 8'(a_iend), 8'd0);
        chk("rs_cirq_idle", 8'(a_cirq), 8'd0);

        // Edge channel 1 pulsed while channel 0 is in service
        b_irq = 2'b10;
        step();
        step();
        chk("ed_cirq0", 8'(b_cirq), 8'd1);
        b_ciack = 1'b1;
        step();
        b_ciack = 1'b0;
        b_irq   = 2'b00;
        step();
        b_irq = 2'b01;
        step();
        b_irq = 2'b00;
        step();
        chk("ed_pend_latched", 8'(b_pend), 8'(2'b01));
        chk("ed_busy_svc", 8'(b_busy), 8'd1);
        chk("ed_cirq_svc", 8'(b_cirq), 8'd0);
        step();
        chk("ed_pend_held", 8'(b_pend), 8'(2'b01));
        b_ciend = 1'b1;
        step();
        chk("ed_iend0", 8'(b_iend), 8'(2'b10));
        b_ciend = 1'b0;
        step();
        chk("ed_idle_gap", 8'(b_cirq), 8'd0);
        step();
        chk("ed_cirq1", 8'(b_cirq), 8'd2);
        b_ciack = 1'b1;
        step();
        chk("ed_iack1", 8'(b_iack), 8'(2'b01));
        chk("ed_pend_clr", 8'(b_pend), 8'd0);
        b_ciack = 1'b0;
        step();
        b_ciend = 1'b1;
        step();
        chk("ed_iend1", 8'(b_iend), 8'(2'b01));
        b_ciend = 1'b0;
        step();

        // Edge coinciding with the acknowledge re-arms the channel
        b_irq = 2'b01;
        step();
        b_irq = 2'b00;
        step();
        chk("ra_cirq", 8'(b_cirq), 8'd2);
        b_ciack = 1'b1;
        b_irq   = 2'b01;
        step();
        chk("ra_iack", 8'(b_iack), 8'(2'b01));
        chk("ra_pend_reset", 8'(b_pend), 8'(2'b01));
        b_ciack = 1'b0;
        step();
        b_ciend = 1'b1;
        step();
        b_ciend = 1'b0;
        step();
        step();
        chk("ra_cirq_again", 8'(b_cirq), 8'd2);
        b_ciack = 1'b1;
        step();
        chk("ra_pend_clr", 8'(b_pend), 8'd0);
        b_ciack = 1'b0;
        step();
        b_ciend = 1'b1;
        step();
        b_ciend = 1'b0;
        step();

        // Input already high across reset counts as a new edge
        rst_n = 1'b0;
        #1;
        chk("hr_pend_rst", 8'(b_pend), 8'd0);
        chk("hr_busy_rst", 8'(b_busy), 8'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("hr_pend", 8'(b_pend), 8'(2'b01));
        step();
        chk("hr_cirq", 8'(b_cirq), 8'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
